traffic_phase_ctrl: RTL and testbench

- Parametrised successor of the two-way traffic controller plus counter pair.
- Single FSM with a shared duration counter drives N approaches in round-robin.
- Each approach gets green, then yellow, then an optional all-red clearance.
- Timing is counted in `tick` units from an external prescaler.
- A latched pedestrian/early-termination request can cut green short once a minimum green time has elapsed.

---
 rtl/traffic_pkg.sv | 27 ++
 rtl/phase_timer.sv | 40 ++++
 rtl/traffic_phase_ctrl.sv | 155 +++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared constants for the traffic phase controller.
//   State codes : ST_ALLRED, ST_GREEN, ST_YELLOW, ST_FLASH (2-bit, matches state_o)
//   LED codes   : {red, yellow, green} per approach
//   max4        : helper for sizing the shared duration counter
package traffic_pkg;

  localparam logic [1:0] ST_ALLRED = 2'd0;
  localparam logic [1:0] ST_GREEN  = 2'd1;
  localparam logic [1:0] ST_YELLOW = 2'd2;
  localparam logic [1:0] ST_FLASH  = 2'd3;

  localparam logic [2:0] LED_RED = 3'b100;
  localparam logic [2:0] LED_YEL = 3'b010;
  localparam logic [2:0] LED_GRN = 3'b001;
  localparam logic [2:0] LED_OFF = 3'b000;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Shared duration counter: counts ticks within the current state.
//   clk, rst_n : clock, async active-low reset
//   tick_i     : time-base enable, count advances only when high
//   clr_i      : synchronous clear (state transition), has priority over tick
//   last_i     : terminal count (duration - 1) of the current state
//   cnt_o      : registered count
//   tc_c_o     : combinational terminal-count strobe (tick_i && cnt == last_i)
module phase_timer #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick_i,
  input  logic          clr_i,
  input  logic [CW-1:0] last_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_c_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign tc_c_o = tick_i && (cnt_q == last_i);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Round-robin N-approach traffic controller: green -> yellow -> all-red per
// approach, timed in ticks, with a latched early-termination request.
//   clk, rst_n  : clock, async active-low reset
//   tick        : time-base enable
//   ped_req     : early-termination request (latched)
//   night_mode  : flashing-yellow hold (only when FLASH_MODE_EN is defined)
//   led_traffic : {red,yellow,green} per approach, registered
//   phase_o     : served approach index
//   state_o     : 0=ALLRED 1=GREEN 2=YELLOW 3=FLASH
// Optional feature macro: FLASH_MODE_EN
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned N_PHASES    = 2,
  parameter int unsigned T_GREEN     = 10,
  parameter int unsigned T_GREEN_MIN = 3,
  parameter int unsigned T_YELLOW    = 5,
  parameter int unsigned T_ALLRED    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    ped_req,
`ifdef FLASH_MODE_EN
  input  logic                    night_mode,
`endif
  output logic [3*N_PHASES-1:0]   led_traffic,
  output logic [2:0]              phase_o,
  output logic [1:0]              state_o
);

  // ALLRED after reset or night mode still lasts at least one tick even when
  // the clearance between phases is skipped.
  localparam int unsigned T_AR_EFF = (T_ALLRED == 0) ? 1 : T_ALLRED;
  localparam int unsigned T_MAX    = max4(T_GREEN, T_YELLOW, T_ALLRED, 2);
  localparam int unsigned CW       = $clog2(T_MAX);

  logic [1:0]            state_q, state_d;
  logic [2:0]            phase_q, phase_d, phase_nxt;
  logic                  req_q, req_d;
  logic [3*N_PHASES-1:0] led_q, led_d;
  logic                  clr;
  logic [CW-1:0]         last, cnt;
  logic                  tc, early;
`ifdef FLASH_MODE_EN
  logic                  flash_q, flash_d;
`endif

  // Terminal count for the current state
  always_comb begin
    case (state_q)
      ST_GREEN:  last = CW'(T_GREEN - 1);
      ST_YELLOW: last = CW'(T_YELLOW - 1);
      default:   last = CW'(T_AR_EFF - 1);
    endcase
  end

  phase_timer #(.CW(CW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_i (tick),
    .clr_i  (clr),
    .last_i (last),
    .cnt_o  (cnt),
    .tc_c_o (tc)
  );

  assign early     = tick && req_q && (cnt >= CW'(T_GREEN_MIN - 1));
  assign phase_nxt = (phase_q == 3'(N_PHASES - 1)) ? 3'd0 : phase_q + 3'd1;

  // Next state, phase and request latch
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    clr     = 1'b0;
    req_d   = req_q | ped_req;
    case (state_q)
      ST_ALLRED: if (tc) begin
        state_d = ST_GREEN;
        phase_d = phase_nxt;
        clr     = 1'b1;
      end
      ST_GREEN: if (tc || early) begin
        // The request that ends green is consumed, even if re-asserted now.
        state_d = ST_YELLOW;
        clr     = 1'b1;
        req_d   = 1'b0;
      end
      ST_YELLOW: if (tc) begin
        clr = 1'b1;
        if (T_ALLRED == 0) begin
          state_d = ST_GREEN;
          phase_d = phase_nxt;
        end else begin
          state_d = ST_ALLRED;
        end
      end
      default: begin
        state_d = ST_ALLRED;
        clr     = 1'b1;
      end
    endcase
`ifdef FLASH_MODE_EN
    flash_d = 1'b1;
    if (night_mode) begin
      state_d = ST_FLASH;
      phase_d = phase_q;
      clr     = 1'b1;
      req_d   = req_q;
      flash_d = (state_q == ST_FLASH) ? (flash_q ^ tick) : 1'b1;
    end
`endif
  end

  // LED decode from next state so the outputs are registered alongside it
  always_comb begin
    led_d = '0;
    for (int k = 0; k < int'(N_PHASES); k++) begin
      led_d[3*k +: 3] = LED_RED;
      if (phase_d == 3'(k)) begin
        if (state_d == ST_GREEN)  led_d[3*k +: 3] = LED_GRN;
        if (state_d == ST_YELLOW) led_d[3*k +: 3] = LED_YEL;
      end
`ifdef FLASH_MODE_EN
      if (state_d == ST_FLASH) led_d[3*k +: 3] = flash_d ? LED_YEL : LED_OFF;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ALLRED;
      phase_q <= 3'(N_PHASES - 1);
      req_q   <= 1'b0;
      led_q   <= {N_PHASES{LED_RED}};
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      req_q   <= req_d;
      led_q   <= led_d;
    end
  end

`ifdef FLASH_MODE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flash_q <= 1'b0;
    else        flash_q <= flash_d;
  end
`endif

  assign led_traffic = led_q;
  assign phase_o     = phase_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench: two controller instances (default, and 4 phases with
// no clearance) driven by directed then random tick/request stimulus and
// compared every cycle against a segment/elapsed-ticks model.
module tb_traffic_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick0 = 1'b0, ped0 = 1'b0, tick1 = 1'b0, ped1 = 1'b0;
  logic [5:0]  led0;
  logic [11:0] led1;
  logic [2:0]  ph0, ph1;
  logic [1:0]  st0, st1;

  always #5 clk = ~clk;

  traffic_phase_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick0), .ped_req(ped0),
`ifdef FLASH_MODE_EN
    .night_mode(1'b0),
`endif
    .led_traffic(led0), .phase_o(ph0), .state_o(st0)
  );

  traffic_phase_ctrl #(.N_PHASES(4), .T_ALLRED(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick1), .ped_req(ped1),
`ifdef FLASH_MODE_EN
    .night_mode(1'b0),
`endif
    .led_traffic(led1), .phase_o(ph1), .state_o(st1)
  );

  int checks = 0;
  int errors = 0;

  // Model: segment 0=red clearance, 1=green, 2=yellow; elapsed ticks in segment
  int m_n[2]   = '{2, 4};
  int m_tg[2]  = '{10, 10};
  int m_tgm[2] = '{3, 3};
  int m_ty[2]  = '{5, 5};
  int m_tar[2] = '{1, 0};
  int m_seg[2], m_phase[2], m_el[2];
  bit m_req[2];

  function automatic void m_reset(int i);
    m_seg[i] = 0; m_phase[i] = m_n[i] - 1; m_el[i] = 0; m_req[i] = 1'b0;
  endfunction

  // Advance the model across one clock edge with the given inputs
  function automatic void m_step(int i, bit t, bit p);
    int el;
    if (!t) begin
      m_req[i] = m_req[i] | p;
      return;
    end
    el = m_el[i] + 1;
    case (m_seg[i])
      1: begin
        if (el == m_tg[i] || (m_req[i] && el >= m_tgm[i])) begin
          m_seg[i] = 2; m_el[i] = 0; m_req[i] = 1'b0;
        end else begin
          m_el[i] = el; m_req[i] = m_req[i] | p;
        end
      end
      2: begin
        m_req[i] = m_req[i] | p;
        if (el == m_ty[i]) begin
          m_el[i] = 0;
          if (m_tar[i] == 0) begin
            m_seg[i] = 1; m_phase[i] = (m_phase[i] + 1) % m_n[i];
          end else begin
            m_seg[i] = 0;
          end
        end else m_el[i] = el;
      end
      default: begin
        m_req[i] = m_req[i] | p;
        if (el >= ((m_tar[i] == 0) ? 1 : m_tar[i])) begin
          m_seg[i] = 1; m_phase[i] = (m_phase[i] + 1) % m_n[i]; m_el[i] = 0;
        end else m_el[i] = el;
      end
    endcase
  endfunction

  function automatic logic [23:0] exp_led(int i);
    logic [23:0] v;
    v = '0;
    for (int k = 0; k < m_n[i]; k++) begin
      if (k == m_phase[i] && m_seg[i] == 1)      v[3*k +: 3] = 3'b001;
      else if (k == m_phase[i] && m_seg[i] == 2) v[3*k +: 3] = 3'b010;
      else                                       v[3*k +: 3] = 3'b100;
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int non_red(input logic [23:0] v, input int n);
    int c;
    c = 0;
    for (int k = 0; k < n; k++) if (v[3*k +: 3] != 3'b100) c++;
    return c;
  endfunction

  task automatic cmp_all();
    logic [23:0] e0, e1;
    e0 = exp_led(0);
    e1 = exp_led(1);
    check("led0",   32'(led0), 32'(e0[5:0]));
    check("phase0", 32'(ph0),  32'(m_phase[0]));
    check("state0", 32'(st0),  32'(m_seg[0]));
    check("one_lit0", 32'(non_red(24'(led0), 2) <= 1), 32'd1);
    check("led1",   32'(led1), 32'(e1[11:0]));
    check("phase1", 32'(ph1),  32'(m_phase[1]));
    check("state1", 32'(st1),  32'(m_seg[1]));
    check("one_lit1", 32'(non_red(24'(led1), 4) <= 1), 32'd1);
  endtask

  initial begin
    int rst_cnt;
    bit rst_done;
    rst_cnt  = 0;
    rst_done = 1'b0;
    m_reset(0);
    m_reset(1);
    repeat (2) @(negedge clk);
    check("rst_led0",   32'(led0), 32'h24);
    check("rst_phase0", 32'(ph0),  32'd1);
    check("rst_state0", 32'(st0),  32'd0);
    check("rst_led1",   32'(led1), 32'h924);
    check("rst_phase1", 32'(ph1),  32'd3);
    rst_n = 1'b1;

    for (int c = 0; c < 2000; c++) begin
      cmp_all();

      // Hand-computed pins on the default instance (tick every cycle from c=0)
      if (c == 1)  begin check("pin_c1_led0",  32'(led0), 32'h21); check("pin_c1_st0", 32'(st0), 32'd1); end
      if (c == 11) check("pin_c11_led0", 32'(led0), 32'h22);
      if (c == 16) begin check("pin_c16_led0", 32'(led0), 32'h24); check("pin_c16_led1", 32'(led1), 32'h90C); end
      if (c == 17) begin check("pin_c17_led0", 32'(led0), 32'h0C); check("pin_c17_ph0", 32'(ph0), 32'd1); end
      if (c == 19) check("pin_early_c19_st0", 32'(st0), 32'd1);
      if (c == 20) check("pin_early_c20_st0", 32'(st0), 32'd2);
      if (c == 79) begin check("pin_frozen_st0", 32'(st0), 32'd1); check("pin_frozen_ph0", 32'(ph0), 32'd0); end
      if (c == 85) check("pin_resume_c85_st0", 32'(st0), 32'd1);
      if (c == 86) check("pin_resume_c86_st0", 32'(st0), 32'd2);

      // Mid-run reset, preferably during yellow of phase 1
      if (!rst_done && c >= 1000 && ((m_seg[0] == 2 && m_phase[0] == 1) || c == 1600)) begin
        rst_n = 1'b0;
        rst_done = 1'b1;
        rst_cnt = 2;
        m_reset(0);
        m_reset(1);
        #1;
        check("async_rst_led0",  32'(led0), 32'h24);
        check("async_rst_led1",  32'(led1), 32'h924);
        check("async_rst_state0", 32'(st0), 32'd0);
      end else if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) rst_n = 1'b1;
      end

      // Stimulus for the next edge
      if (c < 40 && !(c >= 30)) begin
        tick0 = 1'b1; tick1 = 1'b1;
        ped0 = (c == 17); ped1 = (c == 17);
      end else if (c < 80) begin
        tick0 = 1'b0; tick1 = 1'b0;
        ped0 = 1'b0; ped1 = ($urandom_range(0, 9) == 0);
      end else if (c < 90) begin
        tick0 = 1'b1; tick1 = 1'b1; ped0 = 1'b0; ped1 = 1'b0;
      end else begin
        tick0 = ($urandom_range(0, 9) < 7);
        tick1 = ($urandom_range(0, 9) < 7);
        ped0  = ($urandom_range(0, 19) == 0);
        ped1  = ($urandom_range(0, 19) == 0);
      end
      if (rst_n) begin
        m_step(0, tick0, ped0);
        m_step(1, tick1, ped1);
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
